// File: rtl/flash_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single flash read port,
// with round-robin tie-breaking, a one-word read buffer and a WAIT timeout.
module flash_arbiter #(
    parameter int HIT_EN  = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ireq_valid_i,
    input  logic [31:0] ireq_addr_i,
    output logic        ireq_ready_o,
    output logic        iresp_valid_o,
    output logic [31:0] iresp_value_o,
    output logic        iresp_err_o,
    input  logic        dreq_valid_i,
    input  logic [31:0] dreq_addr_i,
    output logic        dreq_ready_o,
    output logic        dresp_valid_o,
    output logic [31:0] dresp_value_o,
    output logic        dresp_err_o,
    output logic        fl_req_valid_o,
    output logic [31:0] fl_req_addr_o,
    input  logic        fl_req_ready_i,
    input  logic        fl_resp_valid_i,
    input  logic [31:0] fl_resp_value_i,
    input  logic        invalidate_i
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_i_q, last_i_d;
    logic          owner_d_q, owner_d_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;
    logic          buf_valid_q, buf_valid_d;
    logic [21:0]   buf_tag_q, buf_tag_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic          iresp_valid_q, iresp_valid_d;
    logic [31:0]   iresp_value_q, iresp_value_d;
    logic          iresp_err_q, iresp_err_d;
    logic          dresp_valid_q, dresp_valid_d;
    logic [31:0]   dresp_value_q, dresp_value_d;
    logic          dresp_err_q, dresp_err_d;

    logic          grant_i, grant_d, accept, hit;
    logic [31:0]   req_addr;
    logic          unused_addr_bits;

    // Tie goes to the port that did not win the previous acceptance.
    assign grant_i  = ireq_valid_i && (!dreq_valid_i || !last_i_q);
    assign grant_d  = dreq_valid_i && (!ireq_valid_i || last_i_q);
    assign ireq_ready_o = (state_q == IDLE) && grant_i;
    assign dreq_ready_o = (state_q == IDLE) && grant_d;
    assign accept   = ireq_ready_o || dreq_ready_o;
    assign req_addr = grant_i ? ireq_addr_i : dreq_addr_i;
    assign hit      = (HIT_EN != 0) && buf_valid_q && !invalidate_i
                      && (buf_tag_q == req_addr[23:2]);

    assign unused_addr_bits = ^{ireq_addr_i[31:24], ireq_addr_i[1:0],
                                dreq_addr_i[31:24], dreq_addr_i[1:0]};

    assign fl_req_valid_o = (state_q == ISSUE);
    assign fl_req_addr_o  = addr_q;
    assign iresp_valid_o  = iresp_valid_q;
    assign iresp_value_o  = iresp_value_q;
    assign iresp_err_o    = iresp_err_q;
    assign dresp_valid_o  = dresp_valid_q;
    assign dresp_value_o  = dresp_value_q;
    assign dresp_err_o    = dresp_err_q;

    always_comb begin
        state_d       = state_q;
        last_i_d      = last_i_q;
        owner_d_d     = owner_d_q;
        addr_d        = addr_q;
        data_d        = data_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        kill_d        = kill_q;
        buf_valid_d   = buf_valid_q;
        buf_tag_d     = buf_tag_q;
        buf_data_d    = buf_data_q;
        iresp_valid_d = 1'b0;
        iresp_value_d = iresp_value_q;
        iresp_err_d   = iresp_err_q;
        dresp_valid_d = 1'b0;
        dresp_value_d = dresp_value_q;
        dresp_err_d   = dresp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d_d = grant_d;
                    last_i_d  = grant_i;
                    addr_d    = {8'h00, req_addr[23:2], 2'b00};
                    kill_d    = 1'b0;
                    cnt_d     = '0;
                    if (hit) begin
                        data_d  = buf_data_q;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (invalidate_i) kill_d = 1'b1;
                if (fl_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (invalidate_i) kill_d = 1'b1;
                if (fl_resp_valid_i) begin
                    data_d  = fl_resp_value_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                    // A fill is dropped if an invalidate was seen while it was in flight.
                    if (!kill_q && !invalidate_i) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = addr_q[23:2];
                        buf_data_d  = fl_resp_value_i;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    data_d  = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (owner_d_q) begin
                    dresp_valid_d = 1'b1;
                    dresp_value_d = data_q;
                    dresp_err_d   = err_q;
                end else begin
                    iresp_valid_d = 1'b1;
                    iresp_value_d = data_q;
                    iresp_err_d   = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (invalidate_i) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            last_i_q      <= 1'b0;
            owner_d_q     <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            kill_q        <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_tag_q     <= '0;
            buf_data_q    <= '0;
            iresp_valid_q <= 1'b0;
            iresp_value_q <= '0;
            iresp_err_q   <= 1'b0;
            dresp_valid_q <= 1'b0;
            dresp_value_q <= '0;
            dresp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_i_q      <= last_i_d;
            owner_d_q     <= owner_d_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            kill_q        <= kill_d;
            buf_valid_q   <= buf_valid_d;
            buf_tag_q     <= buf_tag_d;
            buf_data_q    <= buf_data_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_value_q <= iresp_value_d;
            iresp_err_q   <= iresp_err_d;
            dresp_valid_q <= dresp_valid_d;
            dresp_value_q <= dresp_value_d;
            dresp_err_q   <= dresp_err_d;
        end
    end
endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_flash_arbiter;
    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, ireq_valid_i, dreq_valid_i, fl_req_ready_i, fl_resp_valid_i, invalidate_i;
    logic [31:0] ireq_addr_i, dreq_addr_i, fl_resp_value_i;
    logic        ireq_ready_o, dreq_ready_o, iresp_valid_o, dresp_valid_o, iresp_err_o, dresp_err_o;
    logic        fl_req_valid_o;
    logic [31:0] iresp_value_o, dresp_value_o, fl_req_addr_o;

    flash_arbiter #(.HIT_EN(1), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ireq_valid_i(ireq_valid_i), .ireq_addr_i(ireq_addr_i), .ireq_ready_o(ireq_ready_o),
        .iresp_valid_o(iresp_valid_o), .iresp_value_o(iresp_value_o), .iresp_err_o(iresp_err_o),
        .dreq_valid_i(dreq_valid_i), .dreq_addr_i(dreq_addr_i), .dreq_ready_o(dreq_ready_o),
        .dresp_valid_o(dresp_valid_o), .dresp_value_o(dresp_value_o), .dresp_err_o(dresp_err_o),
        .fl_req_valid_o(fl_req_valid_o), .fl_req_addr_o(fl_req_addr_o), .fl_req_ready_i(fl_req_ready_i),
        .fl_resp_valid_i(fl_resp_valid_i), .fl_resp_value_i(fl_resp_value_i),
        .invalidate_i(invalidate_i)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: one outstanding transaction record plus a one-word buffer.
    bit          m_busy, m_done, m_issued, m_kill, m_owner_d, m_last_i, m_err, m_bv;
    int          m_wait;
    logic [31:0] m_addr, m_val, m_bdata;
    logic [21:0] m_btag;
    logic        e_iv, e_dv, e_ierr, e_derr;
    logic [31:0] e_ival, e_dval;

    task automatic model_step();
        bit gi, gd;
        logic [31:0] a;
        if (rst_i) begin
            m_busy = 0; m_done = 0; m_issued = 0; m_kill = 0; m_owner_d = 0; m_last_i = 0;
            m_err = 0; m_bv = 0; m_wait = 0; m_addr = 0; m_val = 0; m_bdata = 0; m_btag = 0;
            e_iv = 0; e_dv = 0; e_ierr = 0; e_derr = 0; e_ival = 0; e_dval = 0;
            return;
        end
        e_iv = 0;
        e_dv = 0;
        if (m_busy && m_done) begin
            if (m_owner_d) begin e_dv = 1; e_dval = m_val; e_derr = m_err; end
            else begin e_iv = 1; e_ival = m_val; e_ierr = m_err; end
            m_busy = 0;
        end else if (m_busy && !m_issued) begin
            if (invalidate_i) m_kill = 1;
            if (fl_req_ready_i) begin m_issued = 1; m_wait = 0; end
        end else if (m_busy) begin
            if (invalidate_i) m_kill = 1;
            if (fl_resp_valid_i) begin
                m_val = fl_resp_value_i; m_err = 0; m_done = 1;
                if (!m_kill) begin m_bv = 1; m_btag = m_addr[23:2]; m_bdata = fl_resp_value_i; end
            end else if (m_wait == TIMEOUT) begin
                m_val = 32'hFFFF_FFFF; m_err = 1; m_done = 1;
            end else begin
                m_wait++;
            end
        end else begin
            gi = ireq_valid_i && (!dreq_valid_i || !m_last_i);
            gd = dreq_valid_i && !gi;
            if (gi || gd) begin
                a = gi ? ireq_addr_i : dreq_addr_i;
                m_busy = 1; m_owner_d = gd; m_last_i = gi; m_kill = 0; m_issued = 0; m_done = 0;
                m_addr = {8'h00, a[23:2], 2'b00};
                if (m_bv && m_btag == a[23:2] && !invalidate_i) begin
                    m_done = 1; m_val = m_bdata; m_err = 0;
                end
            end
        end
        if (invalidate_i) m_bv = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, mid-low-phase.
    initial forever begin
        bit gi, gd;
        @(negedge clk);
        #2;
        if (chk_en) begin
            gi = !m_busy && ireq_valid_i && (!dreq_valid_i || !m_last_i);
            gd = !m_busy && dreq_valid_i && !(ireq_valid_i && !m_last_i);
            chk("ireq_ready", ireq_ready_o, gi);
            chk("dreq_ready", dreq_ready_o, gd);
            chk("fl_req_valid", fl_req_valid_o, m_busy && !m_issued && !m_done);
            chk("fl_req_addr", fl_req_addr_o, m_addr);
            chk("iresp_valid", iresp_valid_o, e_iv);
            chk("iresp_value", iresp_value_o, e_ival);
            chk("iresp_err", iresp_err_o, e_ierr);
            chk("dresp_valid", dresp_valid_o, e_dv);
            chk("dresp_value", dresp_value_o, e_dval);
            chk("dresp_err", dresp_err_o, e_derr);
        end
    end

    task automatic do_req(input bit is_d, input logic [31:0] addr, input int delay,
                          input logic [31:0] val, input int inv_at,
                          output int lat, output bit saw_fl, output logic [31:0] fa,
                          output logic [31:0] rv, output logic rerr, output bit got);
        bit hs, acc;
        int w;
        hs = 0; w = 0; acc = 0; lat = 0; saw_fl = 0; fa = 0; rv = 0; rerr = 0; got = 0;
        fl_req_ready_i = 1;
        @(negedge clk);
        if (is_d) begin dreq_valid_i = 1; dreq_addr_i = addr; end
        else begin ireq_valid_i = 1; ireq_addr_i = addr; end
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            acc = is_d ? dreq_ready_o : ireq_ready_o;
            if (!acc) @(negedge clk);
        end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL accept_wait: ready never rose for addr %h", addr);
        end
        for (int k = 0; k < TIMEOUT + 50 && !got; k++) begin
            @(negedge clk);
            ireq_valid_i = 0;
            dreq_valid_i = 0;
            lat++;
            fl_resp_valid_i = hs && (w == delay);
            fl_resp_value_i = val;
            invalidate_i    = hs && (w == inv_at);
            #1;
            if (hs) w++;
            if (fl_req_valid_o) begin
                saw_fl = 1;
                fa = fl_req_addr_o;
                if (fl_req_ready_i) begin hs = 1; w = 0; end
            end
            got = is_d ? dresp_valid_o : iresp_valid_o;
            if (got) begin
                rv   = is_d ? dresp_value_o : iresp_value_o;
                rerr = is_d ? dresp_err_o : iresp_err_o;
            end
        end
        fl_resp_valid_i = 0;
        invalidate_i = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
    endtask

    initial begin
        int lat, nresp, nfl;
        bit saw, got, found;
        logic [31:0] fa, rv;
        logic rerr;
        logic [31:0] r;

        rst_i = 1; ireq_valid_i = 0; dreq_valid_i = 0; ireq_addr_i = 0; dreq_addr_i = 0;
        fl_req_ready_i = 0; fl_resp_valid_i = 0; fl_resp_value_i = 0; invalidate_i = 0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        #1;
        chk("rst_fl_req_valid", fl_req_valid_o, 0);
        chk("rst_fl_req_addr", fl_req_addr_o, 0);
        chk("rst_iresp", {iresp_valid_o, iresp_err_o, iresp_value_o[29:0]}, 0);
        chk("rst_dresp", {dresp_valid_o, dresp_err_o, dresp_value_o[29:0]}, 0);
        @(negedge clk);
        rst_i = 0;

        // Miss to flash with a long flash latency.
        do_req(0, 32'h0000_0104, 260, 32'hDEAD_BEEF, -1, lat, saw, fa, rv, rerr, got);
        chk("miss_got", got, 1);
        chk("miss_value", rv, 32'hDEAD_BEEF);
        chk("miss_err", rerr, 0);
        chk("miss_fl_addr", fa, 32'h0000_0104);
        chk("miss_issued", saw, 1);
        $display("txn miss I addr=00000104 value=%h err=%0d lat=%0d", rv, rerr, lat);

        // Same word from the data port: buffer hit.
        do_req(1, 32'h0000_0106, 0, 32'h0BAD_0BAD, -1, lat, saw, fa, rv, rerr, got);
        chk("hit_value", rv, 32'hDEAD_BEEF);
        chk("hit_latency", lat, 2);
        chk("hit_no_flash", saw, 0);
        $display("txn hit D addr=00000106 value=%h lat=%0d", rv, lat);

        // Invalidate during WAIT suppresses the fill; ignored high address bits.
        do_req(0, 32'hAB00_0208, 3, 32'h1234_5678, 1, lat, saw, fa, rv, rerr, got);
        chk("inv_value", rv, 32'h1234_5678);
        chk("inv_fl_addr", fa, 32'h0000_0208);
        do_req(0, 32'h0000_0208, 5, 32'h55AA_55AA, -1, lat, saw, fa, rv, rerr, got);
        chk("inv_reread_miss", saw, 1);
        chk("inv_reread_value", rv, 32'h55AA_55AA);
        do_req(1, 32'h0000_020B, 0, 32'h0, -1, lat, saw, fa, rv, rerr, got);
        chk("refill_hit", saw, 0);
        chk("refill_value", rv, 32'h55AA_55AA);
        $display("txn invalidate/reread value=%h", rv);

        // Round-robin on simultaneous requests starting from reset.
        pulse_reset();
        for (int rr = 0; rr < 4; rr++) begin
            @(negedge clk);
            ireq_valid_i = 1; ireq_addr_i = 32'h300 + 32'(16 * rr);
            dreq_valid_i = 1; dreq_addr_i = 32'h400 + 32'(16 * rr);
            fl_req_ready_i = 1;
            #1;
            chk("rr_grant_i", ireq_ready_o, (rr % 2) == 0);
            chk("rr_grant_d", dreq_ready_o, (rr % 2) == 1);
            found = 0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge clk);
                ireq_valid_i = 0; dreq_valid_i = 0;
                fl_resp_valid_i = 1; fl_resp_value_i = 32'hC0DE_0000 + 32'(rr);
                #1;
                if (iresp_valid_o || dresp_valid_o) begin
                    found = 1;
                    chk("rr_resp_port", dresp_valid_o, (rr % 2) == 1);
                    $display("txn rr=%0d i=%0d d=%0d", rr, iresp_valid_o, dresp_valid_o);
                end
            end
            if (!found) begin
                checks++; failures++;
                $display("FAIL rr_resp_wait: no response in round %0d", rr);
            end
            fl_resp_valid_i = 0;
        end

        // Flash never answers: timeout error response.
        do_req(1, 32'h0000_0500, -1, 32'h0, -1, lat, saw, fa, rv, rerr, got);
        chk("to_got", got, 1);
        chk("to_value", rv, 32'hFFFF_FFFF);
        chk("to_err", rerr, 1);
        $display("txn timeout D value=%h err=%0d lat=%0d", rv, rerr, lat);

        // Reset mid-WAIT: no response, late flash response ignored.
        @(negedge clk);
        ireq_valid_i = 1; ireq_addr_i = 32'h0000_0600; fl_req_ready_i = 1;
        @(negedge clk);
        ireq_valid_i = 0;
        repeat (5) @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        nresp = 0; nfl = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            fl_resp_valid_i = (k < 3);
            fl_resp_value_i = 32'h7777_7777;
            #1;
            if (iresp_valid_o || dresp_valid_o) nresp++;
            if (fl_req_valid_o) nfl++;
        end
        fl_resp_valid_i = 0;
        chk("rst_mid_no_resp", nresp, 0);
        chk("rst_mid_no_flreq", nfl, 0);
        @(negedge clk);
        ireq_valid_i = 1;
        #1;
        chk("rst_mid_ready", ireq_ready_o, 1);
        ireq_valid_i = 0;
        do_req(0, 32'h0000_0600, 2, 32'h0000_0077, -1, lat, saw, fa, rv, rerr, got);
        chk("post_rst_miss", saw, 1);
        chk("post_rst_value", rv, 32'h0000_0077);
        $display("txn reset-mid-wait then read value=%h", rv);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_i = ($urandom_range(0, 599) == 0);
            r = $urandom;
            ireq_valid_i = ($urandom_range(0, 2) == 0);
            ireq_addr_i  = {r[31:24], 20'h0, r[5:4], r[1:0]};
            r = $urandom;
            dreq_valid_i = ($urandom_range(0, 2) == 0);
            dreq_addr_i  = {r[31:24], 20'h0, r[5:4], r[1:0]};
            fl_req_ready_i  = $urandom_range(0, 1) == 1;
            fl_resp_valid_i = ($urandom_range(0, 5) == 0);
            fl_resp_value_i = $urandom;
            invalidate_i    = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        rst_i = 0; ireq_valid_i = 0; dreq_valid_i = 0; fl_resp_valid_i = 0; invalidate_i = 0;
        repeat (5) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter HIT_EN, default 1, enabling the single-word read buffer (0 = every request goes to flash).
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the maximum WAIT cycles before an error response.
REQ-003 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports ireq_valid_i in 1, ireq_addr_i in 32, ireq_ready_o out 1: instruction request.
REQ-006 SHALL have ports iresp_valid_o out 1, iresp_value_o out 32, iresp_err_o out 1: instruction response.
REQ-007 SHALL have ports dreq_valid_i in 1, dreq_addr_i in 32, dreq_ready_o out 1: data request.
REQ-008 SHALL have ports dresp_valid_o out 1, dresp_value_o out 32, dresp_err_o out 1: data response.
REQ-009 SHALL have ports fl_req_valid_o out 1, fl_req_addr_o out 32, fl_req_ready_i in 1: flash controller request.
REQ-010 SHALL have ports fl_resp_valid_i in 1, fl_resp_value_i in 32: flash controller response.
REQ-011 SHALL have port invalidate_i  in  1  clears read buffer.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, RESP; any other encoding returns to IDLE next cycle.
REQ-013 SHALL accept a requester transfer only when its valid and ready are both high in the same cycle.
REQ-014 SHALL drive ireq_ready_o/dreq_ready_o combinationally: high only in IDLE, and only for the granted port.
REQ-015 SHALL grant: single valid port wins; both valid -> port not granted last (round-robin bit, updated on each acceptance).
REQ-016 SHALL latch accepted owner (I/D) and word address {8'h00, addr[23:2], 2'b00}; addr[31:24] and addr[1:0] ignored.
REQ-017 SHALL, on acceptance with HIT_EN=1, buffer valid and buffer tag == addr[23:2], go IDLE->RESP with buffered data (hit, 2-cycle latency accept->resp_valid).
REQ-018 SHALL, on miss, go IDLE->ISSUE, holding fl_req_valid_o=1 and fl_req_addr_o stable until fl_req_valid_o && fl_req_ready_i, then go to WAIT.
REQ-019 SHALL in WAIT count cycles from 0; on fl_resp_valid_i capture fl_resp_value_i, go RESP, err=0.
REQ-020 SHALL, if WAIT counter reaches TIMEOUT without fl_resp_valid_i, go RESP with value 32'hFFFF_FFFF, err=1, buffer not updated.
REQ-021 SHALL in RESP assert owner's resp_valid_o for exactly one cycle with value/err, other port's resp_valid_o low, then return to IDLE.
REQ-022 SHALL hold resp_value_o/resp_err_o stable between responses (registered outputs).
REQ-023 SHALL on successful flash fill write buffer data, tag, valid=1 in the WAIT->RESP transition.
REQ-024 SHALL clear buffer valid when invalidate_i=1; invalidate_i during ISSUE or WAIT suppresses that fill (response still delivered).
REQ-025 SHALL give invalidate_i priority over a fill in the same cycle; a hit check in the same cycle as invalidate_i is a miss.
REQ-026 SHALL ignore fl_resp_valid_i outside WAIT.
REQ-027 SHALL keep fl_req_valid_o low in every state except ISSUE.
REQ-028 SHALL allow at most one outstanding request; no new acceptance before RESP->IDLE.

Reset
REQ-029 SHALL, while rst_i=1 at a clock edge, set state IDLE, round-robin bit so I wins first tie, WAIT counter 0, buffer valid 0, tag/data 0.
REQ-030 SHALL reset outputs: fl_req_valid_o 0, fl_req_addr_o 0, i/dresp_valid_o 0, i/dresp_value_o 0, i/dresp_err_o 0.
REQ-031 SHALL abandon any in-flight request on reset mid-operation with no response; a late fl_resp_valid_i after reset is ignored (IDLE).

Verification
REQ-032 SHALL cover: I reads 0x0000_0104, flash returns 0xDEADBEEF after 260 cycles -> one iresp_valid_o, value 0xDEADBEEF, err 0; fl_req_addr_o 0x0000_0104.
REQ-033 SHALL cover: D reads 0x0000_0106 after previous -> hit, dresp_valid_o 2 cycles after accept, value 0xDEADBEEF, no fl_req_valid_o.
REQ-034 SHALL cover: I and D valid same cycle repeatedly -> grants alternate I, D, I, D; each response to correct port.
REQ-035 SHALL cover: invalidate_i pulsed during WAIT, then same address re-read -> second read misses and issues flash request.
REQ-036 SHALL cover: flash never responds -> resp after TIMEOUT, value 0xFFFF_FFFF, err 1; rst_i asserted mid-WAIT -> no response, ready high in IDLE.
